// File: rtl/rc4_decrypt_compute.sv
// rc4_decrypt_compute
// -----------------------------------------------------------------------------
// RC4 keystream generation and decrypt engine. This block answers the key-search
// controller's compute phase. It walks the already-shuffled S array (256x8 RAM)
// and produces MSG_LEN keystream bytes. Each keystream byte is XORed with the
// encrypted-message ROM, and the result is written to the decrypted-message RAM.
// While it does this it tracks whether every decrypted byte is lowercase ASCII
// or a space.
//
// Parameters
//   MSG_LEN  bytes processed per run (1..256)
//   ADDR_W   ROM / decrypted-RAM address width, 2**ADDR_W >= MSG_LEN
//
// Optional build macro
//   RC4_EARLY_ABORT_EN  when defined, the first out-of-set decrypted byte ends
//                       the run straight after its D write.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start_compute           level request, held high for the whole phase
//   finish_compute          one-cycle done pulse
//   invalid_ascii           sticky out-of-set flag, valid with finish_compute
//   s_addr/s_wdata/s_wren   S RAM port
//   s_rdata                 S RAM read data, 1-cycle latency
//   rom_addr/rom_rdata      encrypted ROM, 1-cycle latency
//   d_addr/d_wdata/d_wren   decrypted RAM write port
//
// Handshake: start_compute is a level. It is sampled in IDLE to begin a run.
// Dropping it during a run aborts at the next edge without a finish pulse.
// After finish_compute, the block parks in WAIT_LOW until start_compute falls,
// so one request produces exactly one run.
//
// Every state lasts one cycle. A byte takes 9 cycles (RD_SI..WR_D). FINISH is
// therefore entered 9*MSG_LEN edges after the edge that samples the start.
// -----------------------------------------------------------------------------
module rc4_decrypt_compute #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_compute,
  output logic              finish_compute,
  output logic              invalid_ascii,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic [ADDR_W-1:0] d_addr,
  output logic [7:0]        d_wdata,
  output logic              d_wren
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_SI    = 4'd1,
    WT_SI    = 4'd2,
    RD_SJ    = 4'd3,
    WT_SJ    = 4'd4,
    WR_SI    = 4'd5,
    WR_SJ    = 4'd6,
    RD_F     = 4'd7,
    WT_F     = 4'd8,
    WR_D     = 4'd9,
    FINISH   = 4'd10,
    WAIT_LOW = 4'd11
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        i, j, si, sj, f, rom_q;
  logic [ADDR_W-1:0] k;
  logic              invalid_q;
  logic [7:0]        d_byte;
  logic              byte_bad;
  logic              busy;

  assign d_byte = f ^ rom_q;
  // Allowed set: 'a'..'z' and space.
  assign byte_bad = !(((d_byte >= 8'h61) && (d_byte <= 8'h7A)) || (d_byte == 8'h20));
  // States in which a falling start_compute aborts the run.
  assign busy = (state != IDLE) && (state != FINISH) && (state != WAIT_LOW);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers, updated according to the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= '0;
      si        <= 8'd0;
      sj        <= 8'd0;
      f         <= 8'd0;
      rom_q     <= 8'd0;
      invalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_compute) begin
            i         <= 8'd0;
            j         <= 8'd0;
            k         <= '0;
            invalid_q <= 1'b0;
          end
        end
        RD_SI: i  <= i + 8'd1;
        WT_SI: si <= s_rdata;
        RD_SJ: j  <= j + si;
        WT_SJ: sj <= s_rdata;
        WT_F: begin
          f     <= s_rdata;
          rom_q <= rom_rdata;
        end
        WR_D: begin
          if (byte_bad) begin
            invalid_q <= 1'b1;
          end
          if (k != LAST_K) begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_compute) state_nxt = RD_SI;
      RD_SI:    state_nxt = WT_SI;
      WT_SI:    state_nxt = RD_SJ;
      RD_SJ:    state_nxt = WT_SJ;
      WT_SJ:    state_nxt = WR_SI;
      WR_SI:    state_nxt = WR_SJ;
      WR_SJ:    state_nxt = RD_F;
      RD_F:     state_nxt = WT_F;
      WT_F:     state_nxt = WR_D;
      WR_D: begin
        if (k == LAST_K) begin
          state_nxt = FINISH;
`ifdef RC4_EARLY_ABORT_EN
        end else if (byte_bad) begin
          state_nxt = FINISH;
`endif
        end else begin
          state_nxt = RD_SI;
        end
      end
      FINISH:   state_nxt = WAIT_LOW;
      WAIT_LOW: if (!start_compute) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (busy && !start_compute) begin
      state_nxt = IDLE;
    end
  end

  // Output decode. Everything is zero outside the state that uses it, so reset
  // (which forces IDLE) clears every output asynchronously.
  always_comb begin
    s_addr         = 8'd0;
    s_wdata        = 8'd0;
    s_wren         = 1'b0;
    rom_addr       = '0;
    d_addr         = '0;
    d_wdata        = 8'd0;
    d_wren         = 1'b0;
    finish_compute = 1'b0;
    case (state)
      RD_SI: s_addr = i + 8'd1;
      RD_SJ: s_addr = j + si;
      WR_SI: begin
        s_addr  = i;
        s_wdata = sj;
        s_wren  = 1'b1;
      end
      // When i==j this overwrites the WR_SI value with si, which is the
      // correct result of the swap.
      WR_SJ: begin
        s_addr  = j;
        s_wdata = si;
        s_wren  = 1'b1;
      end
      RD_F: begin
        s_addr   = si + sj;
        rom_addr = k;
      end
      WR_D: begin
        d_addr  = k;
        d_wdata = d_byte;
        d_wren  = 1'b1;
      end
      FINISH: finish_compute = 1'b1;
      default: ;
    endcase
  end

  assign invalid_ascii = invalid_q;

endmodule

// File: tb/tb_rc4_decrypt_compute.sv
// Testbench for rc4_decrypt_compute.
// Instance sm_dut: MSG_LEN=1 with an identity S array, using hand-computed
// single-byte vectors.
// Instance dut: default MSG_LEN=32. Its S array comes from an RC4 key schedule
// for key 00 02 49. Its ROM holds a known lowercase plaintext encrypted with
// the matching keystream, so the expected D bytes are the plaintext itself.
module tb_rc4_decrypt_compute;

  localparam int W = 13;  // {d_addr[4:0], d_wdata[7:0]}

  logic clk = 1'b0;
  logic reset_n;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- main DUT (MSG_LEN=32) ----------------
  logic       start_compute, finish_compute, invalid_ascii;
  logic [7:0] s_addr, s_wdata, s_rdata;
  logic       s_wren, d_wren;
  logic [4:0] rom_addr, d_addr;
  logic [7:0] rom_rdata, d_wdata;

  rc4_decrypt_compute #(.MSG_LEN(32), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start_compute(start_compute),
    .finish_compute(finish_compute), .invalid_ascii(invalid_ascii),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren)
  );

  logic [7:0] s_mem [256];
  logic [7:0] rom_mem [32];

  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_rdata   <= s_mem[s_addr];
    rom_rdata <= rom_mem[rom_addr];
  end

  // ---------------- small DUT (MSG_LEN=1) ----------------
  logic       sm_start, sm_finish, sm_invalid;
  logic [7:0] sm_s_addr, sm_s_wdata, sm_s_rdata;
  logic       sm_s_wren, sm_d_wren;
  logic [0:0] sm_rom_addr, sm_d_addr;
  logic [7:0] sm_rom_rdata, sm_d_wdata;

  rc4_decrypt_compute #(.MSG_LEN(1), .ADDR_W(1)) sm_dut (
    .clk(clk), .reset_n(reset_n), .start_compute(sm_start),
    .finish_compute(sm_finish), .invalid_ascii(sm_invalid),
    .s_addr(sm_s_addr), .s_wdata(sm_s_wdata), .s_wren(sm_s_wren), .s_rdata(sm_s_rdata),
    .rom_addr(sm_rom_addr), .rom_rdata(sm_rom_rdata),
    .d_addr(sm_d_addr), .d_wdata(sm_d_wdata), .d_wren(sm_d_wren)
  );

  logic [7:0] sm_s_mem [256];
  logic [7:0] sm_rom [2];

  always @(posedge clk) begin
    if (sm_s_wren) sm_s_mem[sm_s_addr] <= sm_s_wdata;
    sm_s_rdata   <= sm_s_mem[sm_s_addr];
    sm_rom_rdata <= sm_rom[sm_rom_addr];
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  int            n_extra = 0;
  int            sm_d_cnt = 0;
  logic [7:0]    sm_d_last = 8'h00;
  logic [15:0]   sm_s_log[$];

  always @(negedge clk) begin
    if (d_wren) begin
      if (exp_q.size() == 0) n_extra++;
      else check_eq("d_write", 32'({d_addr, d_wdata}), 32'(exp_q.pop_front()));
    end
    if (sm_d_wren) begin
      sm_d_cnt++;
      sm_d_last = sm_d_wdata;
    end
    if (sm_s_wren) sm_s_log.push_back({sm_s_addr, sm_s_wdata});
  end

  // ---------------- reference model ----------------
  logic [7:0] key [3];
  logic [7:0] ref_s [256];
  logic [7:0] ks [32];
  string      pt = "the quick brown fox jumps over a";

  task automatic model_ksa();
    logic [7:0] jj, t;
    jj = 8'd0;
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      jj = jj + ref_s[x] + key[x % 3];
      t = ref_s[x]; ref_s[x] = ref_s[jj]; ref_s[jj] = t;
    end
  endtask

  task automatic model_prga();
    logic [7:0] ii, jj, t, idx;
    ii = 8'd0; jj = 8'd0;
    for (int n = 0; n < 32; n++) begin
      ii = ii + 8'd1;
      jj = jj + ref_s[ii];
      t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
      idx = ref_s[ii] + ref_s[jj];
      ks[n] = ref_s[idx];
    end
  endtask

  // Load S, build ROM, and queue the expected D writes. bad_idx<0 means a clean run.
  task automatic prepare(input int bad_idx);
    logic [7:0] c;
    int last;
    model_ksa();
    for (int x = 0; x < 256; x++) s_mem[x] <= ref_s[x];
    model_prga();
    exp_q.delete();
    last = 31;
`ifdef RC4_EARLY_ABORT_EN
    if (bad_idx >= 0) last = bad_idx;
`endif
    for (int n = 0; n < 32; n++) begin
      c = pt[n];
      if (n == bad_idx) c = c ^ 8'h80;
      rom_mem[n] = c ^ ks[n];
      if (n <= last) exp_q.push_back(W'({5'(n), c}));
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_main(output int lat);
    @(negedge clk);
    start_compute = 1'b1;
    @(posedge clk);  // start-sampling edge
    lat = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk); #1;
      if (finish_compute) begin lat = n; break; end
    end
  endtask

  task automatic hold_and_drop(input string tag);
    int fcnt;
    @(posedge clk); #1;
    check_eq({tag, "_finish_one_cycle"}, 32'(finish_compute), 0);
    fcnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (finish_compute) fcnt++;
    end
    check_eq({tag, "_no_refinish"}, fcnt, 0);
    check_eq({tag, "_no_rerun_writes"}, n_extra, 0);
    @(negedge clk);
    start_compute = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic small_run(input string tag, input logic [7:0] rom0,
                           input logic [7:0] exp_d, input logic exp_inv);
    int lat;
    for (int x = 0; x < 256; x++) sm_s_mem[x] <= 8'(x);
    sm_rom[0] = rom0;
    sm_rom[1] = 8'h00;
    sm_d_cnt = 0;
    sm_s_log.delete();
    @(negedge clk);
    sm_start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (sm_finish) begin lat = n; break; end
    end
    check_eq({tag, "_latency"}, lat, 9);
    check_eq({tag, "_invalid"}, 32'(sm_invalid), 32'(exp_inv));
    check_eq({tag, "_d_count"}, sm_d_cnt, 1);
    check_eq({tag, "_d_data"}, 32'(sm_d_last), 32'(exp_d));
    check_eq({tag, "_s_wr_count"}, sm_s_log.size(), 2);
    foreach (sm_s_log[n]) check_eq({tag, "_s_wr"}, 32'(sm_s_log[n]), 32'h0101);
    @(posedge clk); #1;
    check_eq({tag, "_finish_one_cycle"}, 32'(sm_finish), 0);
    @(negedge clk);
    sm_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, fcnt, nbad;
    key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
    reset_n = 1'b0;
    start_compute = 1'b0;
    sm_start = 1'b0;
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'h00;
    sm_rom[0] = 8'h00; sm_rom[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_finish", 32'(finish_compute), 0);
    check_eq("rst_invalid", 32'(invalid_ascii), 0);
    check_eq("rst_s_wren", 32'(s_wren), 0);
    check_eq("rst_d_wren", 32'(d_wren), 0);
    check_eq("rst_s_addr", 32'(s_addr), 0);
    check_eq("rst_rom_addr", 32'(rom_addr), 0);
    check_eq("rst_sm_finish", 32'(sm_finish), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identity S, single byte: f = S[2] = 0x02.
    small_run("id_valid", 8'h63, 8'h61, 1'b0);
    small_run("id_invalid", 8'h00, 8'h02, 1'b1);

    // Run A: byte 3 corrupted -> invalid.
    prepare(3);
    run_main(lat);
`ifdef RC4_EARLY_ABORT_EN
    check_eq("runA_latency", lat, 36);
`else
    check_eq("runA_latency", lat, 288);
`endif
    check_eq("runA_invalid", 32'(invalid_ascii), 1);
    check_eq("runA_all_written", exp_q.size(), 0);
    hold_and_drop("runA");

    // Run B: clean, back-to-back; invalid must clear at the new start.
    prepare(-1);
    run_main(lat);
    check_eq("runB_latency", lat, 288);
    check_eq("runB_invalid", 32'(invalid_ascii), 0);
    check_eq("runB_all_written", exp_q.size(), 0);
    nbad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) nbad++;
    check_eq("runB_s_final_perm", nbad, 0);
    hold_and_drop("runB");

    // Run C: start dropped mid-run -> abort, no finish, no further writes.
    prepare(-1);
    @(negedge clk);
    start_compute = 1'b1;
    repeat (50) @(posedge clk);
    #2 start_compute = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    fcnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (finish_compute) fcnt++;
    end
    check_eq("abort_no_finish", fcnt, 0);
    check_eq("abort_no_writes", n_extra, 0);
    check_eq("abort_invalid_held", 32'(invalid_ascii), 0);

    // Run D: reset asserted at cycle 100, then a fresh run.
    prepare(-1);
    @(negedge clk);
    start_compute = 1'b1;
    repeat (100) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_s_wren", 32'(s_wren), 0);
    check_eq("mid_rst_d_wren", 32'(d_wren), 0);
    check_eq("mid_rst_s_addr", 32'(s_addr), 0);
    check_eq("mid_rst_d_addr", 32'(d_addr), 0);
    check_eq("mid_rst_finish", 32'(finish_compute), 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    start_compute = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_no_writes", n_extra, 0);
    prepare(-1);
    run_main(lat);
    check_eq("runD_latency", lat, 288);
    check_eq("runD_invalid", 32'(invalid_ascii), 0);
    check_eq("runD_all_written", exp_q.size(), 0);
    hold_and_drop("runD");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
